// File: rtl/l2_pmem_burst_adaptor_pkg.sv
// Shared cache constants, line/beat types and the burst adaptor state encoding.
package cache_pkg;

  localparam int LINE_W    = 256;
  localparam int BEAT_W    = 64;
  localparam int NUM_BEATS = LINE_W / BEAT_W;
  localparam int OFFSET_W  = 5;
  localparam int CNT_W     = $clog2(NUM_BEATS);

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/l2_pmem_burst_adaptor.sv
// Whole-line L2 transfers to fixed-length 64-bit pmem bursts.
// Optional perf counters are built when L2_ADAPTOR_PERF_EN is defined.
module l2_pmem_burst_adaptor
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l2_read,
  input  logic              l2_write,
  input  logic [31:0]       l2_address,
  input  logic [LINE_W-1:0] l2_wdata,
  output logic [LINE_W-1:0] l2_rdata,
  output logic              l2_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [1:0]        dbg_state
`ifdef L2_ADAPTOR_PERF_EN
  ,
  output logic [31:0]       perf_reads,
  output logic [31:0]       perf_writes,
  output logic [31:0]       perf_stall_cycles
`endif
);

  // Handshake: a request is held from IDLE until l2_resp; each memory beat
  // is transferred in a READ/WRITE cycle where mem_resp is high.
  adaptor_state_t state_q, state_d;
  cnt_t           cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  line_t          wline_q, wline_d;
  line_t          rline_q, rline_d;
  logic           last_beat;

  assign last_beat = (cnt_q == cnt_t'(NUM_BEATS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    case (state_q)
      IDLE: begin
        if (l2_write || l2_read) begin
          addr_d  = {l2_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
          cnt_d   = '0;
          state_d = l2_write ? WRITE : READ;
          if (l2_write) wline_d = l2_wdata;
        end
      end
      READ: begin
        if (mem_resp) begin
          rline_d[int'(cnt_q)*BEAT_W +: BEAT_W] = mem_rdata;
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      WRITE: begin
        if (mem_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read    = (state_q == READ);
    mem_write   = (state_q == WRITE);
    l2_resp     = (state_q == DONE);
    mem_address = addr_q;
    mem_wdata   = '0;
    if (state_q == WRITE) mem_wdata = wline_q[int'(cnt_q)*BEAT_W +: BEAT_W];
    l2_rdata    = rline_q;
    dbg_state   = state_q;
  end

`ifdef L2_ADAPTOR_PERF_EN
  logic [31:0] perf_reads_q, perf_writes_q, perf_stall_q;
  logic        wr_q;
  assign perf_reads        = perf_reads_q;
  assign perf_writes       = perf_writes_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
`ifdef L2_ADAPTOR_PERF_EN
      perf_reads_q  <= '0;
      perf_writes_q <= '0;
      perf_stall_q  <= '0;
      wr_q          <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
`ifdef L2_ADAPTOR_PERF_EN
      if (state_q == IDLE && (l2_write || l2_read)) wr_q <= l2_write;
      // All counters saturate rather than wrap.
      if (state_q == DONE && !wr_q && perf_reads_q != '1)
        perf_reads_q <= perf_reads_q + 32'd1;
      if (state_q == DONE && wr_q && perf_writes_q != '1)
        perf_writes_q <= perf_writes_q + 32'd1;
      if ((state_q == READ || state_q == WRITE) && !mem_resp && perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_l2_pmem_burst_adaptor.sv
// Directed bench for l2_pmem_burst_adaptor; perf checks only when L2_ADAPTOR_PERF_EN is defined.
module tb_l2_pmem_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         l2_read, l2_write, mem_resp;
  logic [31:0]  l2_address;
  logic [255:0] l2_wdata, l2_rdata;
  logic         l2_resp, mem_read, mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata, mem_rdata;
  logic [1:0]   dbg_state;
`ifdef L2_ADAPTOR_PERF_EN
  logic [31:0]  perf_reads, perf_writes, perf_stall_cycles;
`endif

  int tests = 0;
  int fails = 0;

  // Driver observations from the most recent burst
  int           rd_cyc, wr_cyc, resp_cnt, resp_at;
  bit           addr_bad;
  logic [255:0] rdata_obs;
  logic [63:0]  wq[$];
  logic [63:0]  exp_q[$];

  localparam logic [255:0] LINE_R1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] LINE_W1 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                      64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [255:0] LINE_R2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                      64'h5A5A_5A5A_A5A5_A5A5, 64'hC0DE_0000_0000_BEEF};

  l2_pmem_burst_adaptor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .l2_read    (l2_read),
    .l2_write   (l2_write),
    .l2_address (l2_address),
    .l2_wdata   (l2_wdata),
    .l2_rdata   (l2_rdata),
    .l2_resp    (l2_resp),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp),
    .dbg_state  (dbg_state)
`ifdef L2_ADAPTOR_PERF_EN
    ,
    .perf_reads       (perf_reads),
    .perf_writes      (perf_writes),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // Acts as the L2 and the memory for one transfer; inputs change at negedge.
  task automatic run_burst(input bit do_rd, input bit do_wr, input logic [31:0] addr,
                           input logic [255:0] line, input logic [31:0] exp_addr,
                           input int st_first, input int st_rest, input bit stray);
    int  beat, st, need;
    bit  done;
    rd_cyc = 0; wr_cyc = 0; resp_cnt = 0; resp_at = -1; addr_bad = 0; rdata_obs = '0;
    wq.delete();
    @(negedge clk);
    l2_read = do_rd; l2_write = do_wr; l2_address = addr;
    l2_wdata = do_wr ? line : 256'h0; mem_resp = 1'b0;
    beat = 0; st = 0; done = 0;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(negedge clk);
      mem_resp = 1'b0;
      if (mem_read)  rd_cyc++;
      if (mem_write) wr_cyc++;
      if ((mem_read || mem_write) && mem_address !== exp_addr) addr_bad = 1;
      if (l2_resp === 1'b1) begin
        resp_cnt++; resp_at = cyc; rdata_obs = l2_rdata; done = 1;
        l2_read = 1'b0; l2_write = 1'b0;
        l2_address = 32'hFFFF_FFFF; l2_wdata = '1;
        mem_resp = stray; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end else if ((mem_read || mem_write) && beat < 4) begin
        need = (beat == 0) ? st_first : st_rest;
        if (st < need) st++;
        else begin
          mem_resp = 1'b1;
          mem_rdata = line[beat*64 +: 64];
          if (mem_write) wq.push_back(mem_wdata);
          beat++; st = 0;
        end
      end
    end
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      if (l2_resp === 1'b1) resp_cnt++;
      if (mem_read)  rd_cyc++;
      if (mem_write) wr_cyc++;
    end
    mem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; l2_read = 0; l2_write = 0; l2_address = '0; l2_wdata = '0;
    mem_resp = 0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    tests++; if (mem_read !== 1'b0) begin fails++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
    tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
    tests++; if (l2_resp !== 1'b0) begin fails++; $display("FAIL reset_l2_resp: got %b want 0", l2_resp); end
    tests++; if (mem_address !== 32'h0) begin fails++; $display("FAIL reset_mem_address: got %h want 0", mem_address); end
    tests++; if (mem_wdata !== 64'h0) begin fails++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    tests++; if (l2_rdata !== 256'h0) begin fails++; $display("FAIL reset_l2_rdata: got %h want 0", l2_rdata); end
    tests++; if (dbg_state !== 2'b00) begin fails++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst_n = 1'b1;
  endtask

  task automatic test_read_no_stall();
    run_burst(1, 0, 32'h1234_567F, LINE_R1, 32'h1234_5660, 0, 0, 0);
    tests++; if (resp_cnt !== 1) begin fails++; $display("FAIL read_resp_count: got %0d want 1", resp_cnt); end
    tests++; if (resp_at !== 5) begin fails++; $display("FAIL read_latency: resp at negedge %0d want 5", resp_at); end
    tests++; if (addr_bad) begin fails++; $display("FAIL read_address: got %h want 12345660", mem_address); end
    tests++; if (rd_cyc !== 4) begin fails++; $display("FAIL read_mem_read_cycles: got %0d want 4", rd_cyc); end
    tests++; if (wr_cyc !== 0) begin fails++; $display("FAIL read_mem_write_cycles: got %0d want 0", wr_cyc); end
    tests++; if (rdata_obs !== LINE_R1) begin fails++; $display("FAIL read_rdata: got %h want %h", rdata_obs, LINE_R1); end
    tests++; if (l2_rdata !== LINE_R1) begin fails++; $display("FAIL read_rdata_hold: got %h want %h", l2_rdata, LINE_R1); end
  endtask

  task automatic test_write_stalls();
    exp_q.delete();
    exp_q.push_back(64'hAAAA_AAAA_AAAA_AAAA); exp_q.push_back(64'hBBBB_BBBB_BBBB_BBBB);
    exp_q.push_back(64'hCCCC_CCCC_CCCC_CCCC); exp_q.push_back(64'hDDDD_DDDD_DDDD_DDDD);
    run_burst(0, 1, 32'h8000_0044, LINE_W1, 32'h8000_0040, 2, 2, 0);
    tests++; if (resp_cnt !== 1) begin fails++; $display("FAIL write_resp_count: got %0d want 1", resp_cnt); end
    tests++; if (wr_cyc !== 12) begin fails++; $display("FAIL write_mem_write_cycles: got %0d want 12", wr_cyc); end
    tests++; if (resp_at !== 13) begin fails++; $display("FAIL write_latency: resp at negedge %0d want 13", resp_at); end
    tests++; if (addr_bad) begin fails++; $display("FAIL write_address: got %h want 80000040", mem_address); end
    tests++; if (wq.size() !== 4) begin fails++; $display("FAIL write_beat_count: got %0d want 4", wq.size()); end
    for (int i = 0; i < 4 && wq.size() > 0; i++) begin
      logic [63:0] got, want;
      got = wq.pop_front(); want = exp_q.pop_front();
      tests++; if (got !== want) begin fails++; $display("FAIL write_beat%0d: got %h want %h", i, got, want); end
    end
    tests++; if (l2_rdata !== LINE_R1) begin fails++; $display("FAIL write_keeps_rdata: got %h want %h", l2_rdata, LINE_R1); end
  endtask

  task automatic test_simultaneous();
    run_burst(1, 1, 32'h0000_1000, LINE_W1, 32'h0000_1000, 0, 1, 0);
    tests++; if (rd_cyc !== 0) begin fails++; $display("FAIL simul_mem_read_cycles: got %0d want 0", rd_cyc); end
    tests++; if (wr_cyc !== 7) begin fails++; $display("FAIL simul_mem_write_cycles: got %0d want 7", wr_cyc); end
    tests++; if (resp_cnt !== 1) begin fails++; $display("FAIL simul_resp_count: got %0d want 1", resp_cnt); end
    tests++; if (wq.size() !== 4 || wq[3] !== 64'hDDDD_DDDD_DDDD_DDDD) begin
      fails++; $display("FAIL simul_last_beat: got %0d beats, last %h want DDDDDDDDDDDDDDDD", wq.size(), (wq.size() > 0) ? wq[wq.size()-1] : 64'h0);
    end
  endtask

  task automatic test_reset_mid_burst();
    int resp_seen;
    resp_seen = 0;
    @(negedge clk);
    l2_read = 1'b1; l2_address = 32'h0000_2222;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      if (l2_resp === 1'b1) resp_seen++;
      mem_resp = 1'b1; mem_rdata = LINE_R2[b*64 +: 64];
    end
    @(negedge clk);
    tests++; if (mem_read !== 1'b1) begin fails++; $display("FAIL midrst_pre_mem_read: got %b want 1", mem_read); end
    rst_n = 1'b0; mem_resp = 1'b0; l2_read = 1'b0;
    @(negedge clk);
    if (l2_resp === 1'b1) resp_seen++;
    tests++; if (mem_read !== 1'b0) begin fails++; $display("FAIL midrst_mem_read: got %b want 0", mem_read); end
    tests++; if (dbg_state !== 2'b00) begin fails++; $display("FAIL midrst_state: got %0d want 0", dbg_state); end
    tests++; if (l2_rdata !== 256'h0) begin fails++; $display("FAIL midrst_line_cleared: got %h want 0", l2_rdata); end
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); if (l2_resp === 1'b1) resp_seen++; end
    tests++; if (resp_seen !== 0) begin fails++; $display("FAIL midrst_no_resp: got %0d pulses want 0", resp_seen); end
    run_burst(1, 0, 32'h0000_223F, LINE_R2, 32'h0000_2220, 1, 0, 0);
    tests++; if (resp_cnt !== 1 || rdata_obs !== LINE_R2) begin
      fails++; $display("FAIL midrst_fresh_read: resp %0d data %h want 1 / %h", resp_cnt, rdata_obs, LINE_R2);
    end
  endtask

  task automatic test_back_to_back();
    int total_bursts;
    total_bursts = 0;
    run_burst(0, 1, 32'h4000_0010, LINE_W1, 32'h4000_0000, 0, 0, 1);
    total_bursts += resp_cnt;
    tests++; if (rd_cyc !== 0 || wr_cyc !== 4) begin
      fails++; $display("FAIL b2b_write_cycles: read %0d write %0d want 0/4", rd_cyc, wr_cyc);
    end
    tests++; if (dbg_state !== 2'b00) begin fails++; $display("FAIL b2b_stray_idle_state: got %0d want 0", dbg_state); end
    run_burst(1, 0, 32'h4000_0020, LINE_R1, 32'h4000_0020, 0, 0, 1);
    total_bursts += resp_cnt;
    tests++; if (rd_cyc !== 4 || wr_cyc !== 0) begin
      fails++; $display("FAIL b2b_read_cycles: read %0d write %0d want 4/0", rd_cyc, wr_cyc);
    end
    tests++; if (total_bursts !== 2) begin fails++; $display("FAIL b2b_resp_total: got %0d want 2", total_bursts); end
    tests++; if (l2_rdata !== LINE_R1) begin fails++; $display("FAIL b2b_rdata_after_stray: got %h want %h", l2_rdata, LINE_R1); end
  endtask

`ifdef L2_ADAPTOR_PERF_EN
  task automatic test_perf();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_burst(1, 0, 32'h100, LINE_R1, 32'h100, 1, 0, 0);
    run_burst(1, 0, 32'h200, LINE_R1, 32'h200, 0, 0, 0);
    run_burst(1, 0, 32'h300, LINE_R1, 32'h300, 0, 0, 0);
    run_burst(0, 1, 32'h400, LINE_W1, 32'h400, 1, 1, 0);
    run_burst(0, 1, 32'h500, LINE_W1, 32'h500, 0, 0, 0);
    tests++; if (perf_reads !== 32'd3) begin fails++; $display("FAIL perf_reads: got %0d want 3", perf_reads); end
    tests++; if (perf_writes !== 32'd2) begin fails++; $display("FAIL perf_writes: got %0d want 2", perf_writes); end
    tests++; if (perf_stall_cycles !== 32'd5) begin fails++; $display("FAIL perf_stalls: got %0d want 5", perf_stall_cycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_no_stall();
    test_write_stalls();
    test_simultaneous();
    test_reset_mid_burst();
    test_back_to_back();
`ifdef L2_ADAPTOR_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
